// File: rtl/sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl
//
// Purpose:
//   Multiplexed seven-segment scanner. It drives NUM_DIGITS hex digits one
//   at a time, and each digit stays selected for DWELL_CYCLES clocks.
//   Display inputs are copied into shadow registers only at a frame boundary,
//   so a frame on the pins is never torn. Features:
//     - per-digit blank mask
//     - per-digit decimal-point mask
//     - PWM brightness inside each dwell period
//     - selectable anode and segment polarity
//     - optional leading-zero suppression
//
// Build option:
//   SEVSEG_LZB_EN  When defined, digits above the highest nonzero nibble of
//                  the latched value are kept dark. Digit 0 is always shown.
//                  When undefined, every digit is shown.
//
// Ports:
//   clk_7seg  in   scan clock
//   Rst       in   synchronous reset, active-high
//   value_i   in   [4*NUM_DIGITS] digit k = value_i[4k+3:4k], digit 0 rightmost
//   dp_i      in   [NUM_DIGITS]   1 = light decimal point of digit k
//   blank_i   in   [NUM_DIGITS]   1 = digit k dark
//   bright_i  in   [BR_W]         on-cycles per dwell (0 = dark, >=DWELL = full)
//   an_o      out  [NUM_DIGITS]   anode selects, registered
//   seg_o     out  [7]            {a,b,c,d,e,f,g}, registered
//   dp_o      out                 decimal point, registered
//   frame_o   out                 1-cycle pulse when the shadow registers reload
// ---------------------------------------------------------------------------
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 4,
    parameter int BR_W         = 3,
    parameter int AN_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic                    clk_7seg,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [BR_W-1:0]         bright_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Pin levels for "nothing lit", after the polarity choice is applied.
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;

    // Hex to segment pattern. The table is written active-low; a 0 lights
    // the segment.
    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0: pat = 7'h01;
            4'h1: pat = 7'h4F;
            4'h2: pat = 7'h12;
            4'h3: pat = 7'h06;
            4'h4: pat = 7'h4C;
            4'h5: pat = 7'h24;
            4'h6: pat = 7'h20;
            4'h7: pat = 7'h0F;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h04;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h60;
            4'hC: pat = 7'h31;
            4'hD: pat = 7'h42;
            4'hE: pat = 7'h30;
            default: pat = 7'h38;
        endcase
        return pat;
    endfunction

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Frame shadows
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [BR_W-1:0]         bright_q, bright_d;

    // Output registers
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic                  frame_q, frame_d;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lzb;
    logic                  frame_end;
    logic                  en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = value_q[4*gi +: 4];
        end
    endgenerate

`ifdef SEVSEG_LZB_EN
    // lzb[k] is set when nibbles k..NUM_DIGITS-1 are all zero. It is built as
    // a chain from the top digit downward. It depends only on the shadow
    // value, so it does not change during a frame.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_d0
                assign lzb[gi] = 1'b0;
            end else if (gi == NUM_DIGITS - 1) begin : g_top
                assign lzb[gi] = (nib[gi] == 4'h0);
            end else begin : g_mid
                assign lzb[gi] = lzb[gi+1] & (nib[gi] == 4'h0);
            end
        end
    endgenerate
`else
    assign lzb = '0;
`endif

    always_comb begin
        frame_end = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        value_d  = value_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        bright_d = bright_q;
        frame_d  = frame_end;

        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (frame_end) begin
            value_d  = value_i;
            dp_d     = dp_i;
            blank_d  = blank_i;
            bright_d = bright_i;
        end

        // The PWM compare saturates on its own: cnt never reaches
        // DWELL_CYCLES, so any bright >= DWELL_CYCLES keeps the digit on for
        // the whole dwell.
        en = ~blank_q[idx_q] & (32'(cnt_q) < 32'(bright_q)) & ~lzb[idx_q];

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dpo_d = DP_OFF;
        if (en) begin
            an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
            seg_d = (SEG_ACT_LOW != 0) ? decode(nib[idx_q]) : ~decode(nib[idx_q]);
            dpo_d = (SEG_ACT_LOW != 0) ? ~dp_q[idx_q] : dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            bright_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dpo_q    <= DP_OFF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            bright_q <= bright_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dpo_q    <= dpo_d;
            frame_q  <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dpo_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
//
// Directed bench for sevenseg_scan_ctrl with the default parameters:
// 8 digits, dwell of 4 cycles, active-low pins.
//
// Each step pushes one expected pin state per clock for a whole frame onto a
// queue. The DUT outputs are then checked against that queue on the falling
// edge. The leading-zero expectation follows SEVSEG_LZB_EN.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;

    logic        clk_7seg = 1'b0;
    logic        Rst;
    logic [31:0] value_i;
    logic [7:0]  dp_i;
    logic [7:0]  blank_i;
    logic [2:0]  bright_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    always #5 clk_7seg = ~clk_7seg;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (8),
        .DWELL_CYCLES(4),
        .BR_W        (3),
        .AN_ACT_LOW  (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk_7seg(clk_7seg),
        .Rst     (Rst),
        .value_i (value_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .bright_i(bright_i),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .frame_o (frame_o)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   lzb_on;

    function automatic logic [6:0] seg_code(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        return t[h];
    endfunction

    task automatic push_reset();
        exp_t e;
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fr = 1'b0;
        sb.push_back(e);
    endtask

    // After reset the shadows are zero, so the first frame is dark. The first
    // frame_o arrives on the 32nd clock.
    task automatic push_dark_frame();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fr = (i == 31);
            sb.push_back(e);
        end
    endtask

    // Expected pins for one frame shown from the given shadow contents.
    task automatic push_frame(input logic [31:0] v, input logic [7:0] dpm,
                              input logic [7:0] bl, input logic [2:0] br);
        exp_t e;
        int   top;
        bit   on;
        logic [3:0] h;
        top = -1;
        for (int k = 0; k < 8; k++) begin
            h = v[4*k +: 4];
            if (h != 4'h0) top = k;
        end
        for (int i = 0; i < 32; i++) begin
            int k;
            int c;
            k  = i / 4;
            c  = i % 4;
            on = !bl[k] && (c < int'(br)) && !(lzb_on && k > top && k != 0);
            h  = v[4*k +: 4];
            e.an  = on ? ~(8'h01 << k) : 8'hFF;
            e.seg = on ? seg_code(h) : 7'h7F;
            e.dp  = on ? ~dpm[k] : 1'b1;
            e.fr  = (i == 31);
            sb.push_back(e);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_7seg);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard: got empty queue want entry");
            end else begin
                e = sb.pop_front();
                total++;
                assert (an_o === e.an) else begin
                    bad++;
                    $error("FAIL an_o: got %h want %h", an_o, e.an);
                end
                total++;
                assert (seg_o === e.seg) else begin
                    bad++;
                    $error("FAIL seg_o: got %h want %h", seg_o, e.seg);
                end
                total++;
                assert (dp_o === e.dp) else begin
                    bad++;
                    $error("FAIL dp_o: got %b want %b", dp_o, e.dp);
                end
                total++;
                assert (frame_o === e.fr) else begin
                    bad++;
                    $error("FAIL frame_o: got %b want %b", frame_o, e.fr);
                end
            end
        end
    endtask

    initial begin
`ifdef SEVSEG_LZB_EN
        lzb_on = 1'b1;
`else
        lzb_on = 1'b0;
`endif
        Rst      = 1'b1;
        value_i  = 32'h76543210;
        dp_i     = 8'h00;
        blank_i  = 8'h00;
        bright_i = 3'd4;

        // Reset values, then a dark first frame ending with frame_o.
        push_reset();
        step(1);
        Rst = 1'b0;
        push_dark_frame();
        step(32);
        $display("reset and dark first frame checked");

        // Scan 76543210 at full brightness. The value changes halfway through
        // the frame; the pins must keep the old digits.
        push_frame(32'h76543210, 8'h00, 8'h00, 3'd4);
        step(16);
        value_i = 32'hFFFFFFFF;
        step(16);
        $display("frame 76543210 with mid-frame value change checked");

        push_frame(32'hFFFFFFFF, 8'h00, 8'h00, 3'd4);
        bright_i = 3'd1;
        step(32);
        $display("frame FFFFFFFF checked");

        push_frame(32'hFFFFFFFF, 8'h00, 8'h00, 3'd1);
        bright_i = 3'd0;
        step(32);
        $display("brightness 1 checked");

        push_frame(32'hFFFFFFFF, 8'h00, 8'h00, 3'd0);
        bright_i = 3'd7;
        step(32);
        $display("brightness 0 checked");

        push_frame(32'hFFFFFFFF, 8'h00, 8'h00, 3'd7);
        value_i = 32'h76543210;
        blank_i = 8'h0F;
        dp_i    = 8'h10;
        step(32);
        $display("brightness 7 checked");

        push_frame(32'h76543210, 8'h10, 8'h0F, 3'd7);
        value_i  = 32'h00000A30;
        blank_i  = 8'h00;
        dp_i     = 8'h00;
        bright_i = 3'd4;
        step(32);
        $display("blank 0F / dp 10 checked");

        push_frame(32'h00000A30, 8'h00, 8'h00, 3'd4);
        value_i = 32'h00000000;
        step(32);
        $display("value 00000A30 checked (lzb=%0d)", lzb_on);

        // Value 0, then a reset asserted at idx=5, cnt=2.
        push_frame(32'h00000000, 8'h00, 8'h00, 3'd4);
        step(22);
        Rst = 1'b1;
        sb.delete();
        push_reset();
        step(1);
        Rst = 1'b0;
        $display("value 0 partial frame and mid-frame reset checked");

        push_dark_frame();
        step(32);
        push_frame(32'h00000000, 8'h00, 8'h00, 3'd4);
        step(32);
        $display("restart after reset checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
